// File: rtl/sort_stream_collector.sv
// Receives the sorter's serial output stream, repacks it MSB-first and
// flags ordering and length faults; result is held under a valid/ack handshake.
module sort_stream_collector #(
    parameter int DATA_W   = 8,
    parameter int NUM_ELEM = 8,
    parameter int CNT_W    = $clog2(NUM_ELEM + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_W-1:0]          data_i,
    input  logic                       wr_en_i,
    input  logic                       last_i,
    output logic [NUM_ELEM*DATA_W-1:0] word_o,
    output logic                       valid_o,
    input  logic                       ack_i,
    output logic [CNT_W-1:0]           count_o,
    output logic                       order_err_o,
    output logic                       len_err_o,
    output logic                       drop_o,
    output logic                       busy_o
);

    localparam int WORD_W = NUM_ELEM * DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   prev_q, prev_d;
    logic                valid_q, valid_d;
    logic                order_err_q, order_err_d;
    logic                len_err_q, len_err_d;
    logic                drop_q, drop_d;
    logic                busy_q, busy_d;
    logic                room;

    assign room = (count_q < CNT_W'(NUM_ELEM));

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        count_d     = count_q;
        prev_d      = prev_q;
        order_err_d = order_err_q;
        len_err_d   = len_err_q;
        drop_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (wr_en_i) begin
                    word_d                      = '0;
                    word_d[WORD_W-1 -: DATA_W]  = data_i;
                    count_d                     = CNT_W'(1);
                    prev_d                      = data_i;
                    order_err_d                 = 1'b0;
                    len_err_d                   = last_i && (NUM_ELEM != 1);
                    state_d                     = last_i ? HOLD : COLLECT;
                end
            end
            COLLECT: begin
                if (wr_en_i) begin
                    if (room) begin
                        for (int i = 0; i < NUM_ELEM; i++) begin
                            if (count_q == CNT_W'(i))
                                word_d[WORD_W-1-i*DATA_W -: DATA_W] = data_i;
                        end
                        count_d = count_q + CNT_W'(1);
                        prev_d  = data_i;
                        if (data_i < prev_q)
                            order_err_d = 1'b1;
                    end else begin
                        // frame overran: count saturates, beat is lost
                        drop_d    = 1'b1;
                        len_err_d = 1'b1;
                    end
                    if (last_i) begin
                        state_d = HOLD;
                        if (count_d != CNT_W'(NUM_ELEM))
                            len_err_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (wr_en_i)
                    drop_d = 1'b1;
                if (ack_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        valid_d = (state_d == HOLD);
        busy_d  = (state_d == COLLECT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            word_q      <= '0;
            count_q     <= '0;
            prev_q      <= '0;
            valid_q     <= 1'b0;
            order_err_q <= 1'b0;
            len_err_q   <= 1'b0;
            drop_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            count_q     <= count_d;
            prev_q      <= prev_d;
            valid_q     <= valid_d;
            order_err_q <= order_err_d;
            len_err_q   <= len_err_d;
            drop_q      <= drop_d;
            busy_q      <= busy_d;
        end
    end

    assign word_o      = word_q;
    assign valid_o     = valid_q;
    assign count_o     = count_q;
    assign order_err_o = order_err_q;
    assign len_err_o   = len_err_q;
    assign drop_o      = drop_q;
    assign busy_o      = busy_q;

endmodule
